// File: rtl/vend_pkg.sv
// Shared coin encoding, controller state enum and coin valuation.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;
  localparam logic [1:0] COIN_10   = 2'd2;
  localparam logic [1:0] COIN_BAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHANGE
  } state_t;

  // Coin worth in 5$ units; invalid and empty slots are worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] din);
    case (din)
      COIN_5:  return 2'd1;
      COIN_10: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Loadable down-counter emitting one change pulse per 5$ unit owed.
// Latency: first pulse the cycle after the edge following the load.
// Backpressure: none; busy stays high until the final pulse's edge.
module change_dispenser #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_cnt,
  output logic         change_out,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  // done marks the edge that pays the last unit, so the FSM can leave
  // CHANGE on that same edge and accept a coin on the next one.
  assign done = (cnt == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      change_out <= 1'b0;
      busy       <= 1'b0;
    end else if (load) begin
      cnt        <= load_cnt;
      change_out <= 1'b0;
      busy       <= (load_cnt != '0);
    end else if (cnt != '0) begin
      cnt        <= cnt - W'(1);
      change_out <= 1'b1;
      busy       <= (cnt > W'(1));
    end else begin
      change_out <= 1'b0;
      busy       <= 1'b0;
    end
  end

endmodule

// File: rtl/vend_fsm_param.sv
// N-item vending controller: credit accumulation, vend, cancel refund, serial change.
// Latency: vend/reject pulses one cycle after the coin edge; change follows serially.
// Backpressure: no ready; coins offered while paying change are rejected.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int                          N_ITEMS = 2,
  parameter int                          UNIT_W  = 3,
  parameter logic [N_ITEMS*UNIT_W-1:0]   PRICES  = {3'd2, 3'd1},
  parameter int                          SEL_W   = $clog2(N_ITEMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  sel,
  input  logic [1:0]        din,
  input  logic              cancel,
  output logic [SEL_W:0]    drinks_out,
  output logic              change_out,
  output logic              coin_rej,
  output logic [UNIT_W-1:0] credit,
  output logic              busy
);

  state_t              state, state_nxt;
  logic                coin_in, sel_ok;
  logic [SEL_W-1:0]    sel_idx;
  logic [UNIT_W-1:0]   value, price, sum;
  logic [UNIT_W-1:0]   credit_nxt, load_cnt;
  logic [SEL_W:0]      drinks_nxt;
  logic                rej_nxt, load, done;

  always_comb begin
    coin_in    = (din == COIN_5) || (din == COIN_10);
    sel_ok     = (32'(sel) < N_ITEMS);
    sel_idx    = sel_ok ? sel : '0;
    price      = PRICES[sel_idx*UNIT_W +: UNIT_W];
    value      = UNIT_W'(coin_value(din));
    sum        = credit + value;
    state_nxt  = state;
    credit_nxt = credit;
    drinks_nxt = '0;
    rej_nxt    = 1'b0;
    load       = 1'b0;
    load_cnt   = sum;

    if (state == ST_CHANGE) begin
      rej_nxt = (din != COIN_NONE);
      if (done)
        state_nxt = ST_IDLE;
    end else if (din == COIN_BAD || (coin_in && !sel_ok)) begin
      rej_nxt = 1'b1;
    end else if (coin_in) begin
      if (cancel) begin
        // Coin with cancel: keep the coin in the refund, never vend.
        load       = 1'b1;
        load_cnt   = sum;
        credit_nxt = '0;
        state_nxt  = ST_CHANGE;
      end else if (sum >= price) begin
        drinks_nxt = {1'b0, sel} + (SEL_W+1)'(1);
        load_cnt   = sum - price;
        load       = (load_cnt != '0);
        credit_nxt = '0;
        state_nxt  = load ? ST_CHANGE : ST_IDLE;
      end else begin
        credit_nxt = sum;
        state_nxt  = ST_COLLECT;
      end
    end else if (cancel && state == ST_COLLECT) begin
      load       = 1'b1;
      load_cnt   = credit;
      credit_nxt = '0;
      state_nxt  = ST_CHANGE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      credit     <= '0;
      drinks_out <= '0;
      coin_rej   <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      drinks_out <= drinks_nxt;
      coin_rej   <= rej_nxt;
    end
  end

  change_dispenser #(.W(UNIT_W)) u_change (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_cnt   (load_cnt),
    .change_out (change_out),
    .busy       (busy),
    .done       (done)
  );

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending-machine controller; successor of the fixed two-drink 5$/10$ seller. It supports N selectable items with per-item prices, an accumulated credit register, a cancel/refund request, and serial change dispensing as one pulse per 5$ unit. It sits between the coin acceptor (din) and the dispense/change actuators, in the same clock domain.

## Interface
- N_ITEMS, 2, number of selectable items (≥2)
- UNIT_W, 3, width of price/credit/change counters, in 5$ units
- PRICES, {3'd2,3'd1}, packed N_ITEMS×UNIT_W price list; item i at bits [i*UNIT_W +: UNIT_W]; each price 1..2^UNIT_W−3
- SEL_W, $clog2(N_ITEMS), derived; not overridden
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- sel  input  SEL_W  item select; sampled on every accepted coin
- din  input  2  coin: 0 none, 1 = 5$, 2 = 10$, 3 = invalid
- cancel  input  1  refund all credit, no vend
- drinks_out  output  SEL_W+1  one-cycle pulse, value sel+1 for the vended item; 0 otherwise
- change_out  output  1  one pulse per 5$ returned
- coin_rej  output  1  one-cycle pulse: coin rejected (returned by acceptor)
- credit  output  UNIT_W  current held credit, in 5$ units
- busy  output  1  high in CHANGE state

## Operation
- States: IDLE (credit 0), COLLECT (0 < credit < price), CHANGE (dispensing).
- Coin value: din=1 → 1 unit, din=2 → 2 units. Accepted only in IDLE/COLLECT.
- On accepted coin: sum = credit + value; price = PRICES[sel] at that edge.
  - sum ≥ price: drinks_out ← sel+1; remainder r = sum − price; r>0 → CHANGE with cnt=r, credit=0; r=0 → IDLE.
  - sum < price: credit ← sum, → COLLECT.
- sel change in COLLECT: no action; the next coin compares against the new price. Credit already ≥ new price is not vended until a coin or cancel.
- cancel in COLLECT, no coin: cnt ← credit, credit ← 0, → CHANGE, no vend. cancel in IDLE: ignored.
- cancel with a coin on the same edge: the coin is added, no vend, the entire sum is refunded via CHANGE.
- din=3 in any state, or any coin in CHANGE: coin_rej pulse, no state or credit change.
- CHANGE: change_out=1 for exactly cnt consecutive cycles, cnt decrements each edge; cnt reaching 0 → IDLE.
- Credit never exceeds price_max+1; UNIT_W sized so sum cannot wrap (price limit above).

## Timing
- All outputs registered; reset value 0 for drinks_out, change_out, coin_rej, credit, busy; state IDLE, cnt 0.
- Coin accepted at edge E0 → drinks_out valid in cycle after E0 (latency 1), single cycle.
- With r>0: busy high from E0; change_out high in cycles after E1..Er; state IDLE after Er; next coin accepted at Er+1.
- Cancel at E0 → change_out after E1..E(credit).
- coin_rej asserted the cycle after the offending edge, one cycle per coin.
- Reset mid-operation: outputs clear immediately (async); credit lost, no change paid.

## Structure
- Package vend_pkg: coin encoding constants (COIN_NONE/5/10/BAD), state enum, coin_value() function.
- Sub-module change_dispenser: loadable down-counter with registered pulse output and busy flag; the FSM loads cnt and waits for done.
- Price lookup and compare are combinational in the top level.

## Test plan
- Defaults, sel=0, din=2 one cycle → drinks_out=1 next cycle, then change_out exactly 1 cycle, credit 0, IDLE.
- sel=1, din=1 then din=1 → credit=1 after the first coin; drinks_out=2 after the second; no change_out.
- sel=1, din=1 then din=2 → drinks_out=2, one change_out pulse.
- N_ITEMS=4, PRICES item3=4: sel=3, din=2, din=1, then cancel → 3 change_out pulses, drinks_out stays 0.
- din=3 in IDLE, and din=1 during CHANGE → coin_rej one cycle each; credit and cnt unaffected.
- Reset asserted in COLLECT (credit=1) and mid-CHANGE → all outputs 0 without a clock edge; after release, din=2 with sel=1 vends normally.
